serial_frame_rx: RTL
====================

# serial_frame_rx

Serial frame receiver that sits directly downstream of the single-bit shift register stage and consumes its delayed serial output. It hunts for a sync word in the incoming bitstream, locks, deserializes a fixed number of payload bytes MSB-first, and presents each byte with a one-cycle valid strobe. After the last byte of a frame it returns to hunting for the next sync word.

## Interface
- SYNC_WORD, 8'hA5, frame sync pattern, MSB received first; must be nonzero
- FRAME_LEN, 4, payload bytes per frame, legal range 1..255
- sys_clk  input  1  system clock; all logic on its rising edge
- sys_rst_n  input  1  reset, asynchronous and active-low
- din  input  1  serial data bit from the upstream shift register output
- din_vld  input  1  din is sampled only on cycles where this is 1
- data_out  output  8  last completed payload byte; holds until the next byte completes
- data_valid  output  1  one-cycle pulse, data_out newly updated
- byte_idx  output  8  index (0..FRAME_LEN-1) of the byte on data_out
- sync_det  output  1  one-cycle pulse, sync word matched
- frame_done  output  1  one-cycle pulse, coincident with data_valid of the last byte
- locked  output  1  1 while in PAYLOAD state
- frame_cnt  output  8  completed-frame counter, wraps 255 -> 0

## Operation
- Reset (asynchronous, sys_rst_n = 0): state HUNT; window, payload shifter, bit counter, byte counter = 0; data_out = 0, byte_idx = 0, frame_cnt = 0; data_valid, sync_det, frame_done, locked = 0.
- States: HUNT, PAYLOAD. Nothing changes on cycles with din_vld = 0 except pulse outputs clearing to 0.
- HUNT: each accepted bit shifts an 8-bit window: win <= {win[6:0], din}. If {win[6:0], din} == SYNC_WORD, go to PAYLOAD, pulse sync_det, clear bit counter and byte counter.
- PAYLOAD: each accepted bit shifts the payload shifter MSB-first; bit counter increments 0..7. On the 8th bit: data_out <= {sh[6:0], din}, byte_idx <= byte counter, data_valid pulses, bit counter -> 0, byte counter increments.
- Last byte (byte counter == FRAME_LEN-1 on its 8th bit): frame_done pulses with data_valid, frame_cnt increments (mod 256), state -> HUNT, window cleared to 0.
- Payload bits are never checked against SYNC_WORD; a sync pattern inside the payload is data.
- locked = 1 exactly while state is PAYLOAD.
- sync_det never pulses in the same cycle as data_valid.

## Timing
- All outputs registered; no combinational path from inputs to outputs.
- Sync latency: sync_det and locked rise on the clock edge that samples the final sync bit, so they are visible the cycle after that bit is presented.
- Byte latency: data_valid is high the cycle after the 8th payload bit is presented; data_out is stable from then until the next byte.
- With din_vld held 1: sync_det at bit N, first data_valid 8 cycles later, subsequent bytes every 8 cycles; locked drops in the same cycle frame_done is high.
- Gaps (din_vld = 0) stretch timing; they never drop or duplicate bits and do not reset counters.
- Back-to-back frames: the first bit after the last payload bit is window bit 0; the earliest next sync_det is 8 accepted bits after frame_done.
- Reset asserted mid-frame aborts immediately: partial byte discarded, no data_valid or frame_done, return to HUNT with all counters zeroed.

## Test plan
- Reset: hold sys_rst_n = 0 for 200 ns with din toggling and din_vld = 1 -> all outputs 0, locked = 0, no pulses.
- Basic frame: din_vld = 1, stream 8'hA5 then 8'h11, 8'h22, 8'h33, 8'h44 -> one sync_det, four data_valid pulses 8 cycles apart with data_out 11/22/33/44 and byte_idx 0..3, frame_done with the 8'h44 pulse, frame_cnt = 1, locked = 0 afterwards.
- Sync hunting: prefix 8'h0F, 8'h52 (bit-offset A5 spanning the prefix boundary) before a true A5 -> sync_det exactly at the first bit position where the last 8 bits equal A5; no data_valid before it.
- Payload containing sync: frame with payload A5, A5, A5, A5 -> four data_valid pulses, exactly one sync_det, then HUNT.
- Gapped input: basic frame with din_vld = 0 inserted for 3 cycles after every 2nd bit -> same data_out sequence and byte_idx as the gap-free case, no extra pulses.
- Abort and wrap: assert reset after 12 payload bits -> no data_valid for the partial byte, frame_cnt = 0; then send 256 complete frames -> frame_cnt wraps to 0, 256 frame_done pulses.

Source files
------------

// File: rtl/serial_frame_rx_if.sv
// Serial-in / byte-out bundle for serial_frame_rx.
// The master drives the bit stream and the slave (the receiver) drives the results.
interface serial_frame_rx_if;
  logic       din;
  logic       din_vld;
  logic [7:0] data_out;
  logic       data_valid;
  logic [7:0] byte_idx;
  logic       sync_det;
  logic       frame_done;
  logic       locked;
  logic [7:0] frame_cnt;

  modport master (
    output din, din_vld,
    input  data_out, data_valid, byte_idx, sync_det, frame_done, locked, frame_cnt
  );

  modport slave (
    input  din, din_vld,
    output data_out, data_valid, byte_idx, sync_det, frame_done, locked, frame_cnt
  );
endinterface

// File: rtl/serial_frame_rx.sv
// Receiver that hunts for a sync word in a gated serial stream, then deserializes
// FRAME_LEN payload bytes MSB-first. Each completed byte is flagged with a one-cycle strobe.
module serial_frame_rx #(
  parameter logic [7:0]  SYNC_WORD = 8'hA5,
  parameter int unsigned FRAME_LEN = 4
) (
  input logic              sys_clk,
  input logic              sys_rst_n,
  serial_frame_rx_if.slave bus
);

  localparam logic [7:0] LastIdx = 8'(FRAME_LEN - 1);

  typedef enum logic [0:0] {StHunt, StPayload} state_e;

  state_e     state;
  // Only the seven most recent bits are stored; the incoming bit completes the byte.
  logic [6:0] win;
  logic [6:0] sh;
  logic [2:0] bit_cnt;
  logic [7:0] byte_cnt;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state          <= StHunt;
      win            <= '0;
      sh             <= '0;
      bit_cnt        <= '0;
      byte_cnt       <= '0;
      bus.data_out   <= '0;
      bus.data_valid <= 1'b0;
      bus.byte_idx   <= '0;
      bus.sync_det   <= 1'b0;
      bus.frame_done <= 1'b0;
      bus.locked     <= 1'b0;
      bus.frame_cnt  <= '0;
    end else begin
      bus.data_valid <= 1'b0;
      bus.sync_det   <= 1'b0;
      bus.frame_done <= 1'b0;
      if (bus.din_vld) begin
        unique case (state)
          StHunt: begin
            win <= {win[5:0], bus.din};
            if ({win, bus.din} == SYNC_WORD) begin
              state        <= StPayload;
              bus.locked   <= 1'b1;
              bus.sync_det <= 1'b1;
              bit_cnt      <= '0;
              byte_cnt     <= '0;
            end
          end
          StPayload: begin
            sh      <= {sh[5:0], bus.din};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              bus.data_out   <= {sh, bus.din};
              bus.byte_idx   <= byte_cnt;
              bus.data_valid <= 1'b1;
              byte_cnt       <= byte_cnt + 8'd1;
              if (byte_cnt == LastIdx) begin
                // Clearing the window forces the next sync to use 8 fresh bits.
                bus.frame_done <= 1'b1;
                bus.frame_cnt  <= bus.frame_cnt + 8'd1;
                bus.locked     <= 1'b0;
                state          <= StHunt;
                win            <= '0;
              end
            end
          end
          default: state <= StHunt;
        endcase
      end
    end
  end

endmodule
